// File: rtl/ebus_arb.sv
// ebus_arb: fixed-priority EBUS driver arbiter with registered output,
// multi-driver contention detection/counting and owner hold-timeout check.
// Lowest driving channel index wins; results appear one cycle after sampling.
// Optional build macro: EBUS_HOLD_LAST_EN -- when defined, ebusData keeps its
// last value on idle cycles (bus keeper); otherwise idle cycles drive zeros.
module ebus_arb #(
    parameter int unsigned N_DRV   = 11,
    parameter int unsigned WIDTH   = 36,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rstN,
    input  logic [N_DRV*WIDTH-1:0]     drvData,
    input  logic [N_DRV-1:0]           drvDriving,
    input  logic                       errClr,
    output logic [0:WIDTH-1]           ebusData,
    output logic                       ebusValid,
    output logic [$clog2(N_DRV)-1:0]   ebusOwner,
    output logic                       contention,
    output logic [7:0]                 contentionCnt,
    output logic                       holdTimeout,
    output logic [$clog2(N_DRV)-1:0]   timeoutOwner
);

    localparam int unsigned OW     = $clog2(N_DRV);
    localparam int unsigned RW     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned CW     = 8;
    localparam logic [CW-1:0] CMAX = '1;

    logic             anyDrv;
    logic             multiDrv;
    logic [OW-1:0]    winner;
    logic [WIDTH-1:0] winData;
    logic             sameRun;

    logic [RW-1:0]    runCnt;
    logic [RW-1:0]    runNext;
    logic             toEvent;

    logic             contNext;
    logic [CW-1:0]    cntNext;
    logic             toutNext;
    logic [OW-1:0]    toutOwnerNext;

    // Priority select: first driving channel from index 0 upward wins; a second driver marks contention
    always_comb begin
        anyDrv   = 1'b0;
        multiDrv = 1'b0;
        winner   = '0;
        winData  = '0;
        for (int i = 0; i < int'(N_DRV); i++) begin
            if (drvDriving[i]) begin
                if (anyDrv) begin
                    multiDrv = 1'b1;
                end else begin
                    winner  = OW'(i);
                    winData = drvData[i*WIDTH +: WIDTH];
                end
                anyDrv = 1'b1;
            end
        end
    end

    // The registered output already records last cycle's owner, so it doubles as run history
    assign sameRun = ebusValid && (ebusOwner == winner);

    generate
        if (TIMEOUT == 0) begin : gNoTimeout
            assign runNext = '0;
            assign toEvent = 1'b0;
        end else begin : gTimeout
            // Run-length next state: reload on new owner, count up, saturate at the limit
            always_comb begin
                runNext = '0;
                if (anyDrv) begin
                    if (!sameRun) begin
                        runNext = RW'(1);
                    end else if (runCnt != RW'(TIMEOUT)) begin
                        runNext = RW'(runCnt + RW'(1));
                    end else begin
                        runNext = runCnt;
                    end
                end
            end

            // Timeout fires only on the cycle the run first reaches the limit
            assign toEvent = anyDrv && (runNext == RW'(TIMEOUT))
                             && !(sameRun && (runCnt == RW'(TIMEOUT)));
        end
    endgenerate

    // Error-state next values; a same-cycle error event takes precedence over errClr
    always_comb begin
        contNext      = contention;
        cntNext       = contentionCnt;
        toutNext      = holdTimeout;
        toutOwnerNext = timeoutOwner;

        if (errClr) begin
            contNext      = 1'b0;
            cntNext       = '0;
            toutNext      = 1'b0;
            toutOwnerNext = '0;
        end

        if (multiDrv) begin
            contNext = 1'b1;
            if (errClr) begin
                cntNext = CW'(1);
            end else if (contentionCnt != CMAX) begin
                cntNext = CW'(contentionCnt + CW'(1));
            end
        end

        if (toEvent) begin
            toutNext = 1'b1;
            if (!holdTimeout || errClr) begin
                toutOwnerNext = winner;
            end
        end
    end

    // EBUS output register
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            ebusData  <= '0;
            ebusValid <= 1'b0;
            ebusOwner <= '0;
        end else begin
            ebusValid <= anyDrv;
            if (anyDrv) begin
                ebusData  <= winData;
                ebusOwner <= winner;
            end else begin
`ifdef EBUS_HOLD_LAST_EN
                ebusData  <= ebusData;
`else
                ebusData  <= '0;
`endif
            end
        end
    end

    // Hold run counter
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            runCnt <= '0;
        end else begin
            runCnt <= runNext;
        end
    end

    // Sticky error flags, contention counter and first timeout offender
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            contention    <= 1'b0;
            contentionCnt <= '0;
            holdTimeout   <= 1'b0;
            timeoutOwner  <= '0;
        end else begin
            contention    <= contNext;
            contentionCnt <= cntNext;
            holdTimeout   <= toutNext;
            timeoutOwner  <= toutOwnerNext;
        end
    end

endmodule

// File: tb/tb_ebus_arb.sv
// Directed self-checking bench for ebus_arb (N_DRV=11, WIDTH=36, TIMEOUT=8).
module tb_ebus_arb;

    localparam int unsigned N_DRV   = 11;
    localparam int unsigned WIDTH   = 36;
    localparam int unsigned TIMEOUT = 8;
    localparam int unsigned OW      = $clog2(N_DRV);

    logic                   clk;
    logic                   rstN;
    logic [N_DRV*WIDTH-1:0] drvData;
    logic [N_DRV-1:0]       drvDriving;
    logic                   errClr;
    logic [0:WIDTH-1]       ebusData;
    logic                   ebusValid;
    logic [OW-1:0]          ebusOwner;
    logic                   contention;
    logic [7:0]             contentionCnt;
    logic                   holdTimeout;
    logic [OW-1:0]          timeoutOwner;

    int checks = 0;
    int errors = 0;

    localparam logic [WIDTH-1:0] V4 = 36'o123456701234;
    localparam logic [WIDTH-1:0] D2 = 36'h2_2222_1111;
    localparam logic [WIDTH-1:0] D7 = 36'h7_7777_0000;
    localparam logic [WIDTH-1:0] D5 = 36'h5_0505_0505;
    localparam logic [WIDTH-1:0] D1 = 36'h1_0000_0001;
    localparam logic [WIDTH-1:0] D3 = 36'h3_3030_3030;
    localparam logic [WIDTH-1:0] D6 = 36'hA_BCDE_F012;

    ebus_arb #(.N_DRV(N_DRV), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rstN(rstN), .drvData(drvData), .drvDriving(drvDriving),
        .errClr(errClr), .ebusData(ebusData), .ebusValid(ebusValid),
        .ebusOwner(ebusOwner), .contention(contention), .contentionCnt(contentionCnt),
        .holdTimeout(holdTimeout), .timeoutOwner(timeoutOwner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int ch, input logic [WIDTH-1:0] v);
        drvDriving[ch] = 1'b1;
        drvData[ch*WIDTH +: WIDTH] = v;
    endtask

    task automatic idle();
        drvDriving = '0;
        drvData    = '0;
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_data"},  64'(ebusData), 64'd0);
        check({tag, "_valid"}, 64'(ebusValid), 64'd0);
        check({tag, "_owner"}, 64'(ebusOwner), 64'd0);
        check({tag, "_cont"},  64'(contention), 64'd0);
        check({tag, "_cnt"},   64'(contentionCnt), 64'd0);
        check({tag, "_hto"},   64'(holdTimeout), 64'd0);
        check({tag, "_towner"},64'(timeoutOwner), 64'd0);
    endtask

    initial begin
        rstN   = 1'b0;
        errClr = 1'b0;
        idle();
        #1;
        checkAllZero("reset");
        @(negedge clk);
        rstN = 1'b1;
        tick();

        // Single driver on ch 4
        drive(4, V4);
        tick();
        check("single_data",  64'(ebusData), 64'(V4));
        check("single_owner", 64'(ebusOwner), 64'd4);
        check("single_valid", 64'(ebusValid), 64'd1);
        check("single_cont",  64'(contention), 64'd0);
        idle();
        tick();
        check("idle_valid", 64'(ebusValid), 64'd0);
        check("idle_owner", 64'(ebusOwner), 64'd4);
`ifdef EBUS_HOLD_LAST_EN
        check("idle_data", 64'(ebusData), 64'(V4));
`else
        check("idle_data", 64'(ebusData), 64'd0);
`endif

        // Priority + contention: ch 2 and ch 7 for 3 cycles
        drive(2, D2);
        drive(7, D7);
        repeat (3) tick();
        check("prio_owner", 64'(ebusOwner), 64'd2);
        check("prio_data",  64'(ebusData), 64'(D2));
        check("prio_cont",  64'(contention), 64'd1);
        check("prio_cnt",   64'(contentionCnt), 64'd3);
        check("prio_hto",   64'(holdTimeout), 64'd0);

        // Saturation: 300 contention cycles in a row (ch 2 also exceeds the hold limit)
        repeat (297) tick();
        check("sat_cnt",    64'(contentionCnt), 64'd255);
        check("sat_cont",   64'(contention), 64'd1);
        check("sat_hto",    64'(holdTimeout), 64'd1);
        check("sat_towner", 64'(timeoutOwner), 64'd2);

        // errClr alone on an idle cycle clears all error state
        idle();
        errClr = 1'b1;
        tick();
        errClr = 1'b0;
        check("clr_cont",   64'(contention), 64'd0);
        check("clr_cnt",    64'(contentionCnt), 64'd0);
        check("clr_hto",    64'(holdTimeout), 64'd0);
        check("clr_towner", 64'(timeoutOwner), 64'd0);

        // errClr together with contention: event wins
        drive(2, D2);
        drive(7, D7);
        errClr = 1'b1;
        tick();
        errClr = 1'b0;
        check("clrev_cont", 64'(contention), 64'd1);
        check("clrev_cnt",  64'(contentionCnt), 64'd1);
        check("clrev_hto",  64'(holdTimeout), 64'd0);

        idle();
        errClr = 1'b1;
        tick();
        errClr = 1'b0;

        // Hold timeout: ch 5 continuous
        drive(5, D5);
        repeat (7) tick();
        check("to7_hto", 64'(holdTimeout), 64'd0);
        tick();
        check("to8_hto",    64'(holdTimeout), 64'd1);
        check("to8_towner", 64'(timeoutOwner), 64'd5);
        check("to8_cont",   64'(contention), 64'd0);

        // Later ch 1 timeout keeps the first offender
        idle();
        drive(1, D1);
        repeat (8) tick();
        check("to1_owner",  64'(ebusOwner), 64'd1);
        check("to1_hto",    64'(holdTimeout), 64'd1);
        check("to1_towner", 64'(timeoutOwner), 64'd5);

        // Clear while ch 1 is saturated: no re-trigger
        errClr = 1'b1;
        tick();
        errClr = 1'b0;
        repeat (2) tick();
        check("noretrig_hto",    64'(holdTimeout), 64'd0);
        check("noretrig_towner", 64'(timeoutOwner), 64'd0);

        // Owner switch 5 -> 3 back-to-back, 6 cycles each
        idle();
        tick();
        drive(5, D5);
        repeat (6) tick();
        idle();
        drive(3, D3);
        repeat (6) tick();
        check("switch_owner", 64'(ebusOwner), 64'd3);
        check("switch_data",  64'(ebusData), 64'(D3));
        check("switch_hto",   64'(holdTimeout), 64'd0);

        // Async reset mid-burst on ch 6
        idle();
        drive(6, D6);
        repeat (3) tick();
        check("pre_rst_owner", 64'(ebusOwner), 64'd6);
        #2;
        rstN = 1'b0;
        #1;
        checkAllZero("async_rst");
        #2;
        rstN = 1'b1;
        tick();
        check("post_rst_data",  64'(ebusData), 64'(D6));
        check("post_rst_owner", 64'(ebusOwner), 64'd6);
        check("post_rst_valid", 64'(ebusValid), 64'd1);
        repeat (6) tick();
        check("post_rst_hto7", 64'(holdTimeout), 64'd0);
        tick();
        check("post_rst_hto8",    64'(holdTimeout), 64'd1);
        check("post_rst_towner",  64'(timeoutOwner), 64'd6);

        idle();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ebus_arb.md
# ebus_arb

Parametrised, registered successor to the flat EBUS driver mux. It collects N per-unit EBUS driver channels (data + driving), selects one by fixed priority (lowest index wins), and presents the result on a registered EBUS with owner identification. It also detects and counts multi-driver contention and flags drivers that hold the bus too long. The block sits at top level between the EBOX/MBOX/DTE/RH20 driver channels and the shared EBUS.

## Interface
Parameters:
- `N_DRV`, 11: number of driver channels; legal range 2..32.
- `WIDTH`, 36: EBUS data width; bits are numbered `[0:WIDTH-1]`.
- `TIMEOUT`, 64: consecutive cycles one owner may drive before a hold-timeout error; 0 disables the check.

Ports:
- `clk`, in, 1: the single clock. All state updates on the rising edge.
- `rstN`, in, 1: asynchronous, active-low reset.
- `drvData`, in, N_DRV*WIDTH: channel i's data occupies slice `[i*WIDTH +: WIDTH]`.
- `drvDriving`, in, N_DRV: bit i is channel i's request to drive.
- `errClr`, in, 1: clears the error flags and the contention counter.
- `ebusData`, out, `[0:WIDTH-1]`: registered EBUS data.
- `ebusValid`, out, 1: registered; high when some channel drove in the previous cycle.
- `ebusOwner`, out, $clog2(N_DRV): registered index of the winning channel.
- `contention`, out, 1: sticky; set when two or more channels drive in the same cycle.
- `contentionCnt`, out, 8: saturating count of contention cycles.
- `holdTimeout`, out, 1: sticky hold-timeout error flag.
- `timeoutOwner`, out, $clog2(N_DRV): channel that caused the first timeout since the last clear.

## Operation
- Winner selection: the winner is the lowest index i with `drvDriving[i]=1`. All channels are sampled every cycle; there are no grants and no back-pressure.
- Output register:
  - If any channel drives: `ebusData` takes the winner's data, `ebusOwner` takes the winner index, and `ebusValid` goes to 1.
  - If no channel drives: `ebusValid` goes to 0 and `ebusOwner` holds its value. `ebusData` is set by the configuration macro (see Configuration).
- Contention: in any cycle where popcount(`drvDriving`) ≥ 2:
  - `contention` is set.
  - `contentionCnt` increments, saturating at 255.
  - The winner is still selected normally.
- Hold timer:
  - A run counter counts consecutive cycles in which the same winner index drives.
  - The counter loads 1 when the winner changes or when driving begins after an idle cycle.
  - The counter resets to 0 when no channel drives.
  - When the counter reaches `TIMEOUT`, `holdTimeout` is set. `timeoutOwner` is latched only if `holdTimeout` was previously clear, so the first offender is kept.
  - The counter saturates at `TIMEOUT` and does not re-trigger.
- `errClr`:
  - Clears `contention`, `contentionCnt`, `holdTimeout` and `timeoutOwner`.
  - It does not affect the run counter or the output register.
  - If an error event occurs in the same cycle as `errClr`, the event wins: the flag is set, `contentionCnt` becomes 1, and `timeoutOwner` is loaded.
- With `TIMEOUT`=0, the run counter is tied to 0 and `holdTimeout` stays 0.

## Timing
- Latency is one cycle: inputs sampled at edge k appear on the outputs after edge k.
- Reset: asserting `rstN` low forces every output and internal counter to 0 immediately, regardless of `clk`. This includes `ebusData`, `ebusValid`, `ebusOwner`, `contention`, `contentionCnt`, `holdTimeout`, `timeoutOwner` and the run counter.
- Reset released mid-transaction: the first edge after deassertion samples inputs normally. The run counter restarts at 1 for a driving winner.
- Owner change without an idle cycle (e.g. channel 3 to channel 1 in back-to-back cycles): the run counter reloads to 1, with no gap cycle.
- The contention counter holds at 255 while further contention cycles occur. `contention` remains 1 until cleared.

## Configuration
- `EBUS_HOLD_LAST_EN`:
  - Defined: on idle cycles `ebusData` keeps its previous value (bus-keeper behaviour).
  - Undefined: on idle cycles `ebusData` is driven to all zeros, matching the legacy mux default.
- `ebusValid` behaves identically in both builds.

## Test plan
- Single driver: N_DRV=11, only ch 4 drives 36'o123456701234 for one cycle. Next cycle shows `ebusData`=that value, `ebusOwner`=4, `ebusValid`=1, `contention`=0. The following cycle shows `ebusValid`=0 and `ebusData`=0, or the held value when `EBUS_HOLD_LAST_EN` is defined.
- Priority and contention: ch 2 and ch 7 drive for 3 cycles. Output shows owner 2 and ch 2's data; `contention`=1 and `contentionCnt`=3.
- Saturation and clear: hold contention for 300 cycles, giving `contentionCnt`=255. Assert `errClr` alone and all error state reads 0. Assert `errClr` together with a contention cycle and `contention`=1, `contentionCnt`=1.
- Hold timeout: TIMEOUT=8, ch 5 drives continuously. `holdTimeout` rises on the output after the 8th driving cycle with `timeoutOwner`=5. A later ch 1 timeout does not change `timeoutOwner`.
- Owner switch: TIMEOUT=8, ch 5 drives 6 cycles, then ch 3 drives 6 cycles back-to-back. No timeout occurs.
- Async reset: drop `rstN` mid-burst between clock edges. All outputs read 0 before the next edge. After release, a single driver is output normally one cycle later.
